// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: upstream sequencer for the 3x3 convolution weight tiles.
// Fetches one kernel set from the shared weight banks, then walks an
// odometer over kernel taps (x, y) and output positions (X, Y), and emits
// the load, step and window strobes plus a one-cycle finish pulse.
module conv_scan_ctrl #(
    parameter int KW     = 3,
    parameter int OW     = 19,
    parameter int AW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          xrst,
    input  logic          start,
    input  logic [AW-1:0] kidx,
    input  logic          en,
    output logic [AW-1:0] w_raddr,
    output logic          w_load,
    output logic [1:0]    x,
    output logic [1:0]    y,
    output logic [4:0]    X,
    output logic [4:0]    Y,
    output logic          valid,
    output logic          step_x,
    output logic          step_y,
    output logic          step_X,
    output logic          win_first,
    output logic          win_last,
    output logic          busy,
    output logic          finish
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Terminal values of each counter, sized to the counter they compare with.
    localparam logic [1:0] TAP_LAST = 2'(KW - 1);
    localparam logic [4:0] POS_LAST = 5'(OW - 1);
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

    logic [1:0] state;
    logic [1:0] lat_cnt;

    logic in_run;
    logic adv;
    logic x_last;
    logic y_last;
    logic xx_last;
    logic yy_last;
    logic scan_end;

    // Decode the current count into strobes; everything here is a pure
    // function of state, counters and en so the tiles see it the same cycle.
    always_comb begin
        in_run    = (state == ST_RUN);
        adv       = in_run && en;
        x_last    = (x == TAP_LAST);
        y_last    = (y == TAP_LAST);
        xx_last   = (X == POS_LAST);
        yy_last   = (Y == POS_LAST);
        scan_end  = adv && x_last && y_last && xx_last && yy_last;

        valid     = in_run;
        step_x    = adv && !x_last;
        step_y    = adv && x_last && !y_last;
        step_X    = adv && x_last && y_last && !xx_last;
        win_first = in_run && (x == 2'd0) && (y == 2'd0);
        win_last  = in_run && x_last && y_last;
        busy      = (state != ST_IDLE);
        finish    = (state == ST_DONE);
        w_load    = (state == ST_LOAD) && (lat_cnt == LAT_LAST);
    end

    // Sequencer: accept a start only when idle, wait out the bank read
    // latency, run the scan, then spend one cycle in DONE for the pulse.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state   <= ST_IDLE;
            lat_cnt <= 2'd0;
            w_raddr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        w_raddr <= kidx;
                        lat_cnt <= 2'd0;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (lat_cnt == LAT_LAST) begin
                        state <= ST_RUN;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                ST_RUN: begin
                    if (scan_end) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Tap/position odometer: x fastest, then y, then X, then Y. The final
    // tap wraps every counter back to 0, leaving them clean for the next scan.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            x <= 2'd0;
            y <= 2'd0;
            X <= 5'd0;
            Y <= 5'd0;
        end else if (adv) begin
            if (!x_last) begin
                x <= x + 2'd1;
            end else begin
                x <= 2'd0;
                if (!y_last) begin
                    y <= y + 2'd1;
                end else begin
                    y <= 2'd0;
                    if (!xx_last) begin
                        X <= X + 5'd1;
                    end else begin
                        X <= 5'd0;
                        if (!yy_last) begin
                            Y <= Y + 5'd1;
                        end else begin
                            Y <= 5'd0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Bench for conv_scan_ctrl: a negedge monitor pops expected taps from a
// scoreboard queue filled when each scan is started; scenario tasks check
// timing, stalls, ignored starts and mid-scan reset.
module tb_conv_scan_ctrl;

    localparam int KW    = 3;
    localparam int OW    = 19;
    localparam int NTAPS = KW * KW * OW * OW;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
        logic [4:0] X;
        logic [4:0] Y;
    } tap_t;

    logic       clk;
    logic       xrst;
    logic       start;
    logic [3:0] kidx;
    logic       en;
    logic [3:0] w_raddr;
    logic       w_load;
    logic [1:0] x;
    logic [1:0] y;
    logic [4:0] X;
    logic [4:0] Y;
    logic       valid, step_x, step_y, step_X, win_first, win_last, busy, finish;

    logic       start3;
    logic [3:0] kidx3;
    logic       en3;
    logic [3:0] w_raddr3;
    logic       w_load3;
    logic [1:0] x3;
    logic [1:0] y3;
    logic [4:0] xx3;
    logic [4:0] yy3;
    logic       valid3, step_x3, step_y3, step_xx3, win_first3, win_last3, busy3, finish3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_valid  = 0;
    int n_wlast  = 0;
    int n_stepxx = 0;
    int fin_cnt  = 0;
    int fin_cyc  = -1;
    tap_t last_tap;
    tap_t q[$];

    conv_scan_ctrl #(.KW(KW), .OW(OW), .AW(4), .RD_LAT(1)) dut (
        .clk(clk), .xrst(xrst), .start(start), .kidx(kidx), .en(en),
        .w_raddr(w_raddr), .w_load(w_load), .x(x), .y(y), .X(X), .Y(Y),
        .valid(valid), .step_x(step_x), .step_y(step_y), .step_X(step_X),
        .win_first(win_first), .win_last(win_last), .busy(busy), .finish(finish)
    );

    conv_scan_ctrl #(.KW(KW), .OW(OW), .AW(4), .RD_LAT(3)) dut3 (
        .clk(clk), .xrst(xrst), .start(start3), .kidx(kidx3), .en(en3),
        .w_raddr(w_raddr3), .w_load(w_load3), .x(x3), .y(y3), .X(xx3), .Y(yy3),
        .valid(valid3), .step_x(step_x3), .step_y(step_y3), .step_X(step_xx3),
        .win_first(win_first3), .win_last(win_last3), .busy(busy3), .finish(finish3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Scoreboard consumer: every valid cycle must match the queue head.
    initial begin : monitor
        tap_t e;
        logic [8:0] exp_v;
        logic [8:0] got_v;
        forever begin
            @(negedge clk);
            if (finish) begin
                fin_cnt = fin_cnt + 1;
                fin_cyc = cyc;
            end
            if (step_X) n_stepxx = n_stepxx + 1;
            if (valid) begin
                n_valid  = n_valid + 1;
                if (win_last) n_wlast = n_wlast + 1;
                last_tap = {x, y, X, Y};
                n_checks = n_checks + 1;
                if (q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL sb_empty: valid tap %0d,%0d,%0d,%0d with no expected entry", x, y, X, Y);
                end else begin
                    e = q[0];
                    exp_v = {e.x, e.y, e.X};
                    got_v = {x, y, X};
                    if ({got_v, Y, step_x, step_y, step_X, win_first, win_last} !==
                        {exp_v, e.Y, en && (e.x < 2'(KW-1)),
                         en && (e.x == 2'(KW-1)) && (e.y < 2'(KW-1)),
                         en && (e.x == 2'(KW-1)) && (e.y == 2'(KW-1)) && (e.X < 5'(OW-1)),
                         (e.x == 2'd0) && (e.y == 2'd0),
                         (e.x == 2'(KW-1)) && (e.y == 2'(KW-1))}) begin
                        n_fail = n_fail + 1;
                        $display("FAIL sb_tap: got x%0d y%0d X%0d Y%0d sx%b sy%b sX%b wf%b wl%b, expected x%0d y%0d X%0d Y%0d (en=%b)",
                                 x, y, X, Y, step_x, step_y, step_X, win_first, win_last, e.x, e.y, e.X, e.Y, en);
                    end
                    if (en) void'(q.pop_front());
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_scan();
        tap_t t;
        for (int yy = 0; yy < OW; yy++)
            for (int xx = 0; xx < OW; xx++)
                for (int ky = 0; ky < KW; ky++)
                    for (int kx = 0; kx < KW; kx++) begin
                        t = {2'(kx), 2'(ky), 5'(xx), 5'(yy)};
                        q.push_back(t);
                    end
    endfunction

    function automatic void clear_stats();
        n_valid  = 0;
        n_wlast  = 0;
        n_stepxx = 0;
        fin_cnt  = 0;
        fin_cyc  = -1;
    endfunction

    task automatic test_reset();
        xrst = 1'b0; start = 1'b0; kidx = 4'h0; en = 1'b0;
        start3 = 1'b0; kidx3 = 4'h0; en3 = 1'b0;
        #12;
        n_checks++;
        if ({w_raddr, w_load, x, y, X, Y, valid, step_x, step_y, step_X, win_first, win_last, busy, finish} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {w_raddr, w_load, x, y, X, Y, valid, step_x, step_y, step_X, win_first, win_last, busy, finish});
        end
        next();
        xrst = 1'b1;
        next();
        n_checks++;
        if ({busy, valid, finish} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: busy/valid/finish got %b expected 000", {busy, valid, finish});
        end
    endtask

    task automatic test_first_scan();
        int c0;
        int t;
        clear_stats();
        next();
        start = 1'b1; kidx = 4'hA; en = 1'b1; c0 = cyc;
        push_scan();
        next();
        start = 1'b0;
        n_checks++;
        if ({w_raddr, w_load, valid, busy, step_x} !== {4'hA, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL first_load1: raddr/wload/valid/busy/step_x got %h expected %h",
                     {w_raddr, w_load, valid, busy, step_x}, {4'hA, 4'b0010});
        end
        next();
        n_checks++;
        if ({w_load, valid, step_x} !== 3'b100) begin
            n_fail++;
            $display("FAIL first_wload: wload/valid/step_x got %b expected 100", {w_load, valid, step_x});
        end
        next();
        n_checks++;
        if ({valid, w_load, win_first, x, y, X, Y} !== {3'b101, 14'd0}) begin
            n_fail++;
            $display("FAIL first_tap: valid/wload/wfirst/x/y/X/Y got %h expected %h",
                     {valid, w_load, win_first, x, y, X, Y}, {3'b101, 14'd0});
        end
        t = 0;
        while (fin_cnt == 0 && t < 5000) begin next(); t++; end
        n_checks++;
        if (fin_cnt == 0) begin
            n_fail++;
            $display("FAIL first_timeout: finish count %0d expected 1", fin_cnt);
        end
        n_checks++;
        if (fin_cyc - c0 !== 3252) begin
            n_fail++;
            $display("FAIL first_latency: finish offset %0d expected 3252", fin_cyc - c0);
        end
        n_checks++;
        if ({n_valid, n_wlast, n_stepxx} !== {32'(NTAPS), 32'(OW*OW), 32'((OW-1)*OW)}) begin
            n_fail++;
            $display("FAIL first_counts: valid %0d winlast %0d stepX %0d expected %0d %0d %0d",
                     n_valid, n_wlast, n_stepxx, NTAPS, OW*OW, (OW-1)*OW);
        end
        n_checks++;
        if (last_tap !== {2'd2, 2'd2, 5'd18, 5'd18}) begin
            n_fail++;
            $display("FAIL first_last_tap: got %h expected %h", last_tap, {2'd2, 2'd2, 5'd18, 5'd18});
        end
        n_checks++;
        if ({busy, finish, w_raddr, fin_cnt[1:0]} !== {2'b00, 4'hA, 2'd1}) begin
            n_fail++;
            $display("FAIL first_done: busy/finish/raddr/fincnt got %h expected %h",
                     {busy, finish, w_raddr, fin_cnt[1:0]}, {2'b00, 4'hA, 2'd1});
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL first_sb_drain: %0d taps left expected 0", q.size());
        end
    endtask

    task automatic test_stall();
        int c0;
        int t;
        clear_stats();
        next();
        start = 1'b1; kidx = 4'hA; en = 1'b1; c0 = cyc;
        push_scan();
        next();
        start = 1'b0;
        t = 0;
        while (!(valid && x == 2'd1 && y == 2'd2 && X == 5'd7 && Y == 5'd3) && t < 5000) begin next(); t++; end
        n_checks++;
        if (t >= 5000) begin
            n_fail++;
            $display("FAIL stall_reach: tap 1,2,7,3 not seen within %0d cycles", t);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next();
            en = 1'b0;
            #1;
            n_checks++;
            if ({valid, x, y, X, Y, step_x, step_y, step_X} !== {1'b1, 2'd1, 2'd2, 5'd7, 5'd3, 3'b000}) begin
                n_fail++;
                $display("FAIL stall_frozen: cycle %0d got %h expected %h", i,
                         {valid, x, y, X, Y, step_x, step_y, step_X}, {1'b1, 2'd1, 2'd2, 5'd7, 5'd3, 3'b000});
            end
        end
        next();
        en = 1'b1;
        #1;
        n_checks++;
        if ({x, step_x, step_y} !== {2'd1, 2'b10}) begin
            n_fail++;
            $display("FAIL stall_release: x/step_x/step_y got %h expected %h", {x, step_x, step_y}, {2'd1, 2'b10});
        end
        next();
        n_checks++;
        if ({x, y, X, Y} !== {2'd2, 2'd2, 5'd7, 5'd3}) begin
            n_fail++;
            $display("FAIL stall_resume: got %h expected %h", {x, y, X, Y}, {2'd2, 2'd2, 5'd7, 5'd3});
        end
        t = 0;
        while (fin_cnt == 0 && t < 5000) begin next(); t++; end
        n_checks++;
        if (fin_cyc - c0 !== 3257) begin
            n_fail++;
            $display("FAIL stall_latency: finish offset %0d expected 3257", fin_cyc - c0);
        end
        n_checks++;
        if ({n_valid, n_wlast} !== {32'(NTAPS + 5), 32'(OW*OW)}) begin
            n_fail++;
            $display("FAIL stall_counts: valid %0d winlast %0d expected %0d %0d", n_valid, n_wlast, NTAPS + 5, OW*OW);
        end
    endtask

    task automatic test_start_ignored();
        int c0;
        int t;
        clear_stats();
        next();
        start = 1'b1; kidx = 4'hA; en = 1'b1; c0 = cyc;
        push_scan();
        next();
        start = 1'b0;
        repeat (100) next();
        start = 1'b1; kidx = 4'h3;
        next();
        start = 1'b0;
        n_checks++;
        if ({w_raddr, busy} !== {4'hA, 1'b1}) begin
            n_fail++;
            $display("FAIL busy_start: raddr/busy got %h expected %h", {w_raddr, busy}, {4'hA, 1'b1});
        end
        t = 0;
        while (cyc < c0 + 3252 && t < 5000) begin next(); t++; end
        n_checks++;
        if (finish !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_finish_cycle: finish got %b expected 1", finish);
        end
        start = 1'b1; kidx = 4'h3;
        next();
        start = 1'b0;
        n_checks++;
        if ({busy, w_raddr} !== {1'b0, 4'hA}) begin
            n_fail++;
            $display("FAIL finish_start: busy/raddr got %h expected %h", {busy, w_raddr}, {1'b0, 4'hA});
        end
        next();
        n_checks++;
        if ({busy, fin_cnt[1:0], n_valid} !== {1'b0, 2'd1, 32'(NTAPS)}) begin
            n_fail++;
            $display("FAIL ign_after: busy %b fincnt %0d valid %0d expected 0 1 %0d", busy, fin_cnt, n_valid, NTAPS);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        int t;
        clear_stats();
        next();
        start = 1'b1; kidx = 4'hA; en = 1'b1;
        push_scan();
        next();
        start = 1'b0;
        t = 0;
        while (!(valid && X == 5'd10) && t < 5000) begin next(); t++; end
        xrst = 1'b0;
        #1;
        n_checks++;
        if ({w_raddr, w_load, x, y, X, Y, valid, step_x, step_y, step_X, win_first, win_last, busy, finish} !== 26'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h expected 0",
                     {w_raddr, w_load, x, y, X, Y, valid, step_x, step_y, step_X, win_first, win_last, busy, finish});
        end
        q.delete();
        repeat (3) next();
        n_checks++;
        if (fin_cnt !== 0) begin
            n_fail++;
            $display("FAIL midreset_finish: finish count %0d expected 0", fin_cnt);
        end
        xrst = 1'b1;
        next();
        clear_stats();
        start = 1'b1; kidx = 4'hA; c0 = cyc;
        push_scan();
        next();
        start = 1'b0;
        t = 0;
        while (fin_cnt == 0 && t < 5000) begin next(); t++; end
        n_checks++;
        if ({n_valid, fin_cyc - c0} !== {32'(NTAPS), 32'd3252}) begin
            n_fail++;
            $display("FAIL rescan: valid %0d offset %0d expected %0d 3252", n_valid, fin_cyc - c0, NTAPS);
        end
    endtask

    task automatic test_rdlat3();
        next();
        start3 = 1'b1; kidx3 = 4'h5; en3 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            next();
            start3 = 1'b0;
            n_checks++;
            if ({w_load3, valid3, busy3, w_raddr3} !== {(k == 4), (k == 5), 1'b1, 4'h5}) begin
                n_fail++;
                $display("FAIL rdlat3_c%0d: wload/valid/busy/raddr got %h expected %h", k,
                         {w_load3, valid3, busy3, w_raddr3}, {(k == 4), (k == 5), 1'b1, 4'h5});
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_scan();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_rdlat3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
